// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared types and constants for the fetch/load-store memory arbiter
package rv_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic OWN_IF    = 1'b0;
  localparam logic OWN_D     = 1'b1;
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] limit);
    return (v >= limit) ? limit : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - 8-bit response timeout counter with clear, enable and expired flag
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Flags the cycle in which the count reaches the limit, so the owner can abort in that same cycle.
  assign expired = (count_d == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rtl/rv_mem_arbiter.sv - arbitrates instruction fetch and load/store onto one single-port memory
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [7:0]        burst_q, burst_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              fetch_win;
  logic              tmo_expired;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == S_IDLE),
    .en     (state_q == S_WAIT),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_win   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          // Data normally wins; fetch is forced once a data burst has starved it long enough.
          fetch_win = if_req && (!d_req || (burst_q == BURST_MAX));
          if (fetch_win) begin
            owner_d     = OWN_IF;
            burst_d     = '0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end else begin
            owner_d     = OWN_D;
            burst_d     = if_req ? sat_inc(burst_q, BURST_MAX) : 8'd0;
            mem_we_d    = (d_rw == MEM_WRITE);
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
          mem_req_d = 1'b1;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
          if (owner_q == OWN_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_we_q ? '0 : mem_rdata;
          end
        end else if (tmo_expired) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_RESP;
          if (owner_q == OWN_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      burst_q     <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-port memory between instruction fetch and the load/store path of the RV32I core, now that the core is moving to a shared memory.
- Grants one requester per access and drives a valid/ready-style memory handshake.
- Returns read data and a done/error pulse to the granted requester, and enforces fairness and a response timeout.
- The data-port request is the decoder's MemEnable; the data-port direction is its MemFunc (1 = read, 0 = write).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles waiting for mem_ready before abort (range 1..255, counter 8 bits).
- MAX_BURST, 4, consecutive data grants allowed while fetch is pending before fetch is forced.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_done  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  fetched word; valid while if_done is high
- d_req  in  1  data request (MemEnable); held until d_done
- d_rw  in  1  1 = read, 0 = write (MemFunc)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data; valid while d_done is high
- err  out  1  pulse coincident with a done pulse when the access timed out
- busy  out  1  high whenever state is not IDLE
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion, sampled while mem_req is high

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; burst and timeout counters 0.
- States: IDLE, WAIT, RESP.
- IDLE, no requests: remain in IDLE.
- IDLE, arbitration when any request is present:
  - d_req wins, unless if_req is high AND burst count == MAX_BURST; then fetch wins.
  - Burst count increments on a data grant taken while if_req is high (saturates at MAX_BURST).
  - Burst count clears on any fetch grant, and on a data grant taken with if_req low.
- IDLE, on grant:
  - Latch owner, mem_addr, mem_we (= ~d_rw for data, 0 for fetch) and mem_wdata (0 for fetch).
  - Set mem_req = 1 and go to WAIT.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Timeout counter increments each cycle.
  - mem_ready high: capture mem_rdata into the owner's rdata register; mem_req -> 0; go to RESP.
  - Counter reaches TIMEOUT with mem_ready low: mem_req -> 0; rdata -> 0; set err; go to RESP.
- RESP:
  - Exactly one cycle.
  - Owner's done pulse is high; err is high only on the timeout path.
  - No arbitration in RESP; always go to IDLE.
  - The requester must drop req (or present a new request) by the next cycle, which prevents a double grant.
- Minimum latency: req sampled at edge 1 -> mem_req high in cycle 1 -> mem_ready in cycle 1 -> done in cycle 2 -> IDLE in cycle 3.
  - Peak rate: one access per 3 cycles.
- Writes: d_rdata = 0 on d_done.
- The non-owner's done and rdata are untouched: done stays 0, rdata keeps its last value.
- mem_ready outside WAIT is ignored.
- A request deasserted during WAIT (protocol violation) does not abort the access; done still pulses.
- Reset mid-access: immediate return to IDLE with mem_req = 0. The abandoned access is never reported and the memory must tolerate the dropped request.
- Timeout counter clears on every entry to WAIT.

Decomposition:
- Package rv_mem_pkg:
  - State encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2).
  - Owner constants (OWN_IF = 1'b0, OWN_D = 1'b1).
  - MEM_READ = 1'b1, MEM_WRITE = 1'b0, matching the decoder's MemFunc encoding.
- Sub-module mem_timeout_ctr: 8-bit counter with clear, enable and expired flag (count == TIMEOUT).

Test Plan:
- Single load: d_req = 1, d_rw = 1, d_addr = 0x100; mem_ready one cycle after mem_req with mem_rdata = 0xDEADBEEF -> mem_we = 0, mem_addr = 0x100, d_done pulse for 1 cycle with d_rdata = 0xDEADBEEF; if_done stays 0.
- Store: d_req = 1, d_rw = 0, d_addr = 0x40, d_wdata = 0x12345678 -> mem_we = 1, mem_wdata = 0x12345678; d_done pulses with d_rdata = 0.
- Simultaneous: if_req and d_req both high in IDLE, burst = 0 -> data granted first, fetch granted next (after RESP and IDLE). Sustained d_req with if_req held -> fetch is forced after exactly 4 data grants.
- Timeout: TIMEOUT = 5, mem_ready held 0 -> mem_req high for exactly 5 cycles, then err and if_done pulse together with if_rdata = 0.
- Reset mid-WAIT: assert rst during WAIT -> mem_req, busy and all done outputs go to 0 immediately. After release, a new if_req completes normally.
- Spurious mem_ready in IDLE and RESP -> no done pulse, no data capture.
